// File: rtl/restriction_equiv_sweeper.sv
// Exhaustive equivalence sweeper: drives vectors 0..2^NIN-1 to an original and a restricted
// datapath and compares their LAT-aligned outputs. Define EVAL_READY_EN for eval_ready_i flow control.
module restriction_equiv_sweeper #(
  parameter int NIN          = 5,
  parameter int LAT          = 0,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  output logic [NIN-1:0] vec_o,
  output logic           vec_valid_o,
  input  logic           f_ref_i,
  input  logic           f_res_i,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [NIN-1:0] fail_vec,
  output logic [NIN:0]   mismatch_count
`ifdef EVAL_READY_EN
  ,
  input  logic           eval_ready_i
`endif
);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

  localparam logic [NIN:0] LAST      = {1'b0, {NIN{1'b1}}};
  localparam logic [NIN:0] SAT       = {1'b1, {NIN{1'b0}}};
  localparam logic [2:0]   DRAIN_END = 3'(LAT - 1);
  localparam logic         STOP_EN   = (STOP_ON_FAIL != 0);

  state_t         state, state_nxt;
  logic           adv;
  logic [NIN:0]   cnt;
  logic [2:0]     dcnt;
  logic           fail_seen;
  logic           full_ok;
  logic           cmp_vld;
  logic [NIN-1:0] cmp_vec;
  logic           idle_like, start_hit, abort_hit;
  logic           mismatch, first_stop, last_acc;

`ifdef EVAL_READY_EN
  assign adv = eval_ready_i;
`else
  assign adv = 1'b1;
`endif

  assign idle_like   = (state == IDLE) || (state == DONE);
  assign start_hit   = start & idle_like;
  assign abort_hit   = abort & ~idle_like;
  assign vec_o       = cnt[NIN-1:0];
  assign vec_valid_o = (state == SWEEP);
  assign busy        = ~idle_like;
  assign done        = (state == DONE);
  assign pass        = done & full_ok & (mismatch_count == '0);

  // Results still in flight when an abort lands are discarded, not counted.
  assign mismatch   = cmp_vld & adv & ~abort_hit & (f_ref_i ^ f_res_i);
  assign first_stop = STOP_EN & mismatch & ~fail_seen & vec_valid_o;
  assign last_acc   = vec_valid_o & adv & (cnt == LAST);

  // Stage boundary: vec_o -> LAT-deep alignment with the datapath outputs
  if (LAT == 0) begin : g_nodly
    assign cmp_vld = vec_valid_o;
    assign cmp_vec = vec_o;
  end else begin : g_dly
    logic [NIN-1:0] vec_p [LAT];
    logic [LAT-1:0] vld_p;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < LAT; i++) vec_p[i] <= '0;
        vld_p <= '0;
      end else if (start_hit || abort_hit) begin
        vld_p <= '0;
      end else if (adv) begin
        vec_p[0] <= vec_o;
        vld_p[0] <= vec_valid_o;
        for (int i = 1; i < LAT; i++) begin
          vec_p[i] <= vec_p[i-1];
          vld_p[i] <= vld_p[i-1];
        end
      end
    end

    assign cmp_vld = vld_p[LAT-1];
    assign cmp_vec = vec_p[LAT-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = SWEEP;
      SWEEP: begin
        if (abort)                       state_nxt = DONE;
        else if (first_stop || last_acc) state_nxt = (LAT == 0) ? DONE : DRAIN;
      end
      DRAIN: begin
        if (abort)                           state_nxt = DONE;
        else if (adv && dcnt == DRAIN_END)   state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage boundary: vector counter, drain timer and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt            <= '0;
      dcnt           <= '0;
      fail_seen      <= 1'b0;
      full_ok        <= 1'b0;
      fail_vec       <= '0;
      mismatch_count <= '0;
    end else if (start_hit) begin
      cnt            <= '0;
      dcnt           <= '0;
      fail_seen      <= 1'b0;
      full_ok        <= 1'b0;
      fail_vec       <= '0;
      mismatch_count <= '0;
    end else begin
      if (vec_valid_o && adv && !abort_hit && !first_stop && cnt != LAST)
        cnt <= cnt + 1'b1;
      if (abort_hit)
        full_ok <= 1'b0;
      else if (last_acc)
        full_ok <= 1'b1;
      if (state == SWEEP)
        dcnt <= '0;
      else if (state == DRAIN && adv)
        dcnt <= dcnt + 3'd1;
      if (mismatch) begin
        if (mismatch_count != SAT) mismatch_count <= mismatch_count + 1'b1;
        if (!fail_seen) begin
          fail_vec  <= cmp_vec;
          fail_seen <= 1'b1;
        end
      end
    end
  end

endmodule
